actor_trigger_ctrl: RTL and testbench

//  Per-actor launch controller between the network start/stop logic and one HLS actor core (ap_ctrl_hs).

---
 rtl/actor_trigger_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_actor_trigger_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/actor_trigger_ctrl.sv
// rtl/actor_trigger_ctrl.sv - per-actor launch/sleep controller for an ap_ctrl_hs HLS actor (optional TRIGGER_STATS_EN)
//
// Macro TRIGGER_STATS_EN adds stat_launches / stat_fired counters and ports.
module actor_trigger_ctrl #(
  parameter int SLEEP_THRESHOLD = 2,
  parameter int CNT_W           = 32
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             ap_start,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             ap_ready,
  output logic             actor_start,
  input  logic             actor_done,
  input  logic             actor_idle,
  input  logic [31:0]      actor_return,
  input  logic             external_enqueue,
  input  logic             all_sleep,
  output logic             sleep
`ifdef TRIGGER_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_launches,
  output logic [CNT_W-1:0] stat_fired
`endif
);

  // Sleep counter only needs to reach the threshold, so size it for that.
  localparam int SC_W = (SLEEP_THRESHOLD < 1) ? 1 : $clog2(SLEEP_THRESHOLD + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(SLEEP_THRESHOLD);

  // Actor return code meaning "the actor fired"; anything above it is also
  // treated as a firing so a corrupted code can never end the invocation.
  localparam logic [31:0] RET_EXECUTED = 32'd5;

  typedef enum logic [1:0] {
    STAND_BY     = 2'd0,
    TRY_LAUNCH   = 2'd1,
    LAUNCH       = 2'd2,
    CHECK_RETURN = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [SC_W-1:0]  r_sleep_cnt;
  logic             r_sleep;
  logic             r_ap_done;

  logic             w_start_inv;
  logic             w_eval;
  logic             w_fired;
  logic             w_finish;
  logic             w_actor_start;

  // A new invocation begins when a start request is seen while standing by.
  assign w_start_inv   = (r_state == STAND_BY) && ap_start;

  // A return is consumed whenever the actor reports done while we own it,
  // either in the launch cycle itself or while waiting for completion.
  assign w_eval        = actor_done && ((r_state == LAUNCH) || (r_state == CHECK_RETURN));

  assign w_fired       = (actor_return >= RET_EXECUTED);

  // Sleep is the registered flag, so finishing needs the count to have
  // already reached the threshold before this return arrived.
  assign w_finish      = w_eval && !w_fired && r_sleep && all_sleep && !external_enqueue;

  assign w_actor_start = (r_state == LAUNCH);

  // State register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= STAND_BY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      STAND_BY: begin
        if (ap_start) begin
          w_next_state = TRY_LAUNCH;
        end
      end
      TRY_LAUNCH: begin
        if (actor_idle) begin
          w_next_state = LAUNCH;
        end
      end
      LAUNCH: begin
        if (actor_done) begin
          w_next_state = w_finish ? STAND_BY : LAUNCH;
        end else begin
          w_next_state = CHECK_RETURN;
        end
      end
      CHECK_RETURN: begin
        if (actor_done) begin
          w_next_state = w_finish ? STAND_BY : LAUNCH;
        end
      end
      default: begin
        w_next_state = STAND_BY;
      end
    endcase
  end

  // Output logic: Moore handshakes plus the registered done/sleep flags
  always_comb begin
    actor_start = 1'b0;
    ap_idle     = 1'b0;
    ap_done     = 1'b0;
    ap_ready    = 1'b0;
    sleep       = 1'b0;
    actor_start = w_actor_start;
    ap_idle     = (r_state == STAND_BY);
    ap_done     = r_ap_done;
    ap_ready    = r_ap_done;
    sleep       = r_sleep;
  end

  // Consecutive non-firing return counter; neighbour activity wakes us first
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_sleep_cnt <= '0;
    end else if (w_start_inv) begin
      r_sleep_cnt <= '0;
    end else if (external_enqueue) begin
      r_sleep_cnt <= '0;
    end else if (w_eval) begin
      if (w_fired) begin
        r_sleep_cnt <= '0;
      end else if (r_sleep_cnt < SC_MAX) begin
        r_sleep_cnt <= r_sleep_cnt + SC_W'(1);
      end
    end
  end

  // Registered sleep flag keeps all_sleep free of combinational loops
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_sleep <= 1'b0;
    end else begin
      r_sleep <= (r_sleep_cnt >= SC_MAX);
    end
  end

  // One-cycle done pulse, raised in the cycle STAND_BY is re-entered
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_ap_done <= 1'b0;
    end else begin
      r_ap_done <= w_finish;
    end
  end

`ifdef TRIGGER_STATS_EN
  logic [CNT_W-1:0] r_stat_launches;
  logic [CNT_W-1:0] r_stat_fired;

  // Per-invocation statistics, saturating at all-ones
  always_ff @(posedge ap_clk) begin
    if (ap_rst || w_start_inv) begin
      r_stat_launches <= '0;
      r_stat_fired    <= '0;
    end else begin
      if (w_actor_start && !(&r_stat_launches)) begin
        r_stat_launches <= r_stat_launches + CNT_W'(1);
      end
      if (w_eval && w_fired && !(&r_stat_fired)) begin
        r_stat_fired <= r_stat_fired + CNT_W'(1);
      end
    end
  end

  assign stat_launches = r_stat_launches;
  assign stat_fired    = r_stat_fired;
`else
  localparam int cnt_w_unused = CNT_W;
`endif

endmodule

// File: tb/tb_actor_trigger_ctrl.sv
// tb/tb_actor_trigger_ctrl.sv - scoreboard bench for actor_trigger_ctrl
module tb_actor_trigger_ctrl;

  localparam int TH = 2;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic        actor_start;
  logic        actor_done;
  logic        actor_idle;
  logic [31:0] actor_return;
  logic        external_enqueue;
  logic        all_sleep;
  logic        sleep;
`ifdef TRIGGER_STATS_EN
  logic [31:0] stat_launches;
  logic [31:0] stat_fired;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_launch = 0;
  int m_run = 0;
  bit exp_q[$];

  actor_trigger_ctrl #(.SLEEP_THRESHOLD(TH), .CNT_W(32)) dut (
    .ap_clk           (ap_clk),
    .ap_rst           (ap_rst),
    .ap_start         (ap_start),
    .ap_done          (ap_done),
    .ap_idle          (ap_idle),
    .ap_ready         (ap_ready),
    .actor_start      (actor_start),
    .actor_done       (actor_done),
    .actor_idle       (actor_idle),
    .actor_return     (actor_return),
    .external_enqueue (external_enqueue),
    .all_sleep        (all_sleep),
    .sleep            (sleep)
`ifdef TRIGGER_STATS_EN
    ,
    .stat_launches    (stat_launches),
    .stat_fired       (stat_fired)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  always @(negedge ap_clk) begin
    if (actor_start) n_launch++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  // Bounded wait for the next launch cycle; leaves us inside it.
  task automatic wait_start();
    for (int i = 0; i < 20; i++) begin
      if (actor_start) break;
      step();
    end
    chk("launch_wait", 32'(actor_start), 32'd1);
  endtask

  // Called in a launch cycle: waits lat cycles, delivers one return,
  // then checks the outcome predicted by the run-length model.
  task automatic run_return(input logic [31:0] ret, input bit enq, input int lat, input int exp_sleep);
    bit fired;
    bit exp_fin;
    bit e;
    for (int i = 0; i < lat; i++) step();
    if (exp_sleep >= 0) chk("sleep_pre", 32'(sleep), 32'(exp_sleep));
    actor_done       = 1'b1;
    actor_return     = ret;
    external_enqueue = enq;
    fired   = (ret >= 32'd5);
    exp_fin = !fired && (m_run >= TH) && all_sleep && !enq;
    if (enq || fired) m_run = 0;
    else if (m_run < TH) m_run = m_run + 1;
    exp_q.push_back(exp_fin);
    step();
    actor_done       = 1'b0;
    actor_return     = 32'd0;
    external_enqueue = 1'b0;
    e = exp_q.pop_front();
    chk("ap_done", 32'(ap_done), 32'(e));
    chk("ap_ready", 32'(ap_ready), 32'(e));
    chk("relaunch", 32'(actor_start), 32'(!e));
  endtask

  initial begin
    int snap;
    bit any_done;
    ap_rst = 1'b1; ap_start = 1'b0; actor_done = 1'b0; actor_idle = 1'b1;
    actor_return = 32'd0; external_enqueue = 1'b0; all_sleep = 1'b1;
    step(); step(); step();
    chk("rst_actor_start", 32'(actor_start), 32'd0);
    chk("rst_ap_done", 32'(ap_done), 32'd0);
    chk("rst_ap_ready", 32'(ap_ready), 32'd0);
    chk("rst_ap_idle", 32'(ap_idle), 32'd1);
    chk("rst_sleep", 32'(sleep), 32'd0);

    // 1: launch timing
    ap_rst = 1'b0;
    ap_start = 1'b1;
    step();
    chk("c1_ap_idle", 32'(ap_idle), 32'd0);
    chk("c1_actor_start", 32'(actor_start), 32'd0);
    step();
    chk("c2_actor_start", 32'(actor_start), 32'd1);

    // 2: 5,5,2,2,2 with all_sleep=1
    m_run = 0;
    run_return(32'd5, 1'b0, 0, -1);
    run_return(32'd5, 1'b0, 0, -1);
    run_return(32'd2, 1'b0, 1, 0);
    run_return(32'd2, 1'b0, 1, -1);
    run_return(32'd2, 1'b0, 1, 1);
    chk("t2_idle_at_done", 32'(ap_idle), 32'd1);
    // back-to-back restart, held off by a busy actor
    actor_idle = 1'b0;
    step();
    chk("b2b_idle", 32'(ap_idle), 32'd0);
    step(); step();
    chk("try_hold", 32'(actor_start), 32'd0);
    actor_idle = 1'b1;
    step();
    chk("try_launch", 32'(actor_start), 32'd1);

    // 3: enqueue wakes the actor; ap_start dropping mid-run is ignored
    m_run = 0;
    run_return(32'd2, 1'b0, 1, -1);
    ap_start = 1'b0;
    run_return(32'd2, 1'b0, 1, -1);
    run_return(32'd2, 1'b1, 1, -1);
    run_return(32'd2, 1'b0, 2, 0);
    run_return(32'd2, 1'b0, 1, -1);
    run_return(32'd2, 1'b0, 1, -1);

    // 4: all_sleep low keeps relaunching
    ap_start = 1'b1;
    step();
    wait_start();
    ap_start = 1'b0;
    m_run = 0;
    all_sleep = 1'b0;
    snap = n_launch;
    for (int i = 0; i < 10; i++) run_return(32'd3, 1'b0, 1, -1);
    chk("t4_launches", 32'(n_launch - snap), 32'd10);
    chk("t4_sleep", 32'(sleep), 32'd1);
    all_sleep = 1'b1;
    run_return(32'd3, 1'b0, 1, -1);

    // 5: out-of-range return codes count as firing
    ap_start = 1'b1;
    step();
    wait_start();
    ap_start = 1'b0;
    m_run = 0;
    run_return(32'h7, 1'b0, 0, -1);
    run_return(32'h7, 1'b0, 1, -1);
    run_return(32'hFFFF_FFFF, 1'b0, 1, -1);
    run_return(32'h6, 1'b0, 1, 0);
`ifdef TRIGGER_STATS_EN
    chk("t5_stat_fired", stat_fired, 32'd4);
`endif
    run_return(32'd0, 1'b0, 1, -1);
    run_return(32'd4, 1'b0, 1, -1);
    run_return(32'd1, 1'b0, 1, -1);

    // 6: reset while waiting for the actor
    ap_start = 1'b1;
    step();
    wait_start();
    m_run = 0;
    all_sleep = 1'b0;
    run_return(32'd2, 1'b0, 1, -1);
    run_return(32'd2, 1'b0, 1, -1);
    run_return(32'd2, 1'b0, 1, -1);
    step();
    chk("t6_pre_sleep", 32'(sleep), 32'd1);
    ap_rst = 1'b1;
    ap_start = 1'b0;
    step();
    chk("t6_idle", 32'(ap_idle), 32'd1);
    chk("t6_actor_start", 32'(actor_start), 32'd0);
    chk("t6_sleep", 32'(sleep), 32'd0);
    chk("t6_ap_done", 32'(ap_done), 32'd0);
    ap_rst = 1'b0;
    any_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ap_done) any_done = 1'b1;
    end
    chk("t6_no_done", 32'(any_done), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
